// File: rtl/lsu_map_pkg.sv
// Memory map, timer register offsets and bridge FSM state type for the LSU MMIO bridge.
// Also provides the byte-strobe merge used by every strobed register write.
package lsu_map_pkg;

    localparam logic [31:0] RAM_BASE_DEF   = 32'h0000_0000;
    localparam logic [31:0] TIMER_BASE_DEF = 32'h0200_0000;

    localparam logic [3:0] MTIME_LO    = 4'h0;
    localparam logic [3:0] MTIME_HI    = 4'h4;
    localparam logic [3:0] MTIMECMP_LO = 4'h8;
    localparam logic [3:0] MTIMECMP_HI = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        RELEASE
    } bridge_state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_mmio_bridge_if.sv
// Core load/store request/response bundle; the core is the master, the bridge the slave.
interface lsu_mmio_bridge_if;

    logic        rready_cpu;
    logic        rvalid_cpu;
    logic        wvalid_cpu;
    logic        wready_cpu;
    logic [3:0]  strb_cpu;
    logic [31:0] addr_cpu;
    logic [31:0] data_cpu_o;
    logic [31:0] data_cpu_i;

    modport master (
        output rready_cpu,
        output wvalid_cpu,
        output strb_cpu,
        output addr_cpu,
        output data_cpu_o,
        input  rvalid_cpu,
        input  wready_cpu,
        input  data_cpu_i
    );

    modport slave (
        input  rready_cpu,
        input  wvalid_cpu,
        input  strb_cpu,
        input  addr_cpu,
        input  data_cpu_o,
        output rvalid_cpu,
        output wready_cpu,
        output data_cpu_i
    );

endinterface

// File: rtl/mtimer.sv
// Machine timer: free-running 64-bit mtime with prescaler, mtimecmp and registered irq compare.
// Strobed CPU writes to mtime take priority over the increment in the same cycle.
module mtimer
    import lsu_map_pkg::*;
#(
    parameter int unsigned TIMER_PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_off,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_off,
    output logic [31:0] rd_data,
    output logic        timer_irq
);

    localparam logic [31:0] PrescMax = 32'(TIMER_PRESCALE - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] presc_q, presc_d;
    logic        irq_q, irq_d;
    logic        tick;

    always_comb begin
        tick       = (presc_q == PrescMax);
        presc_d    = tick ? '0 : presc_q + 32'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            // Merging into mtime_q (not the incremented value) drops the tick on a mtime write.
            case (wr_off)
                MTIME_LO:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wr_data, wr_strb)};
                MTIME_HI:    mtime_d = {merge_bytes(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
                MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                           merge_bytes(mtimecmp_q[31:0], wr_data, wr_strb)};
                MTIMECMP_HI: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb),
                                           mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    assign irq_d = (mtime_q >= mtimecmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            MTIME_LO:    rd_data = mtime_q[31:0];
            MTIME_HI:    rd_data = mtime_q[63:32];
            MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
            MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
            default: ;
        endcase
    end

    assign timer_irq = irq_q;

endmodule

// File: rtl/lsu_mmio_bridge.sv
// Routes core load/store requests to the data RAM or the machine timer, with a
// one-cycle response and a release phase that suppresses repeat responses to held requests.
module lsu_mmio_bridge
    import lsu_map_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_D   = 10,
    parameter logic [31:0] RAM_BASE       = RAM_BASE_DEF,
    parameter logic [31:0] TIMER_BASE     = TIMER_BASE_DEF,
    parameter int unsigned TIMER_PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lsu_mmio_bridge_if.slave        cpu,
    output logic                    ram_en,
    output logic [3:0]              ram_we,
    output logic [ADDR_WIDTH_D-1:0] ram_addr,
    output logic [31:0]             ram_wdata,
    input  logic [31:0]             ram_rdata,
    output logic                    timer_irq,
    output logic                    bus_err
);

    localparam int unsigned RamLsb = ADDR_WIDTH_D + 2;

    bridge_state_t state_q, state_d;

    logic        ram_hit, tmr_hit;
    logic        acc_wr, acc_rd, accept;
    logic [31:0] tmr_rd_data;

    logic        is_wr_q, is_wr_d;
    logic        from_ram_q, from_ram_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // RAM wins if a misconfigured map makes the windows overlap.
    assign ram_hit = (cpu.addr_cpu[31:RamLsb] == RAM_BASE[31:RamLsb]);
    assign tmr_hit = !ram_hit && (cpu.addr_cpu[31:4] == TIMER_BASE[31:4]);

    // rst_n gating keeps RAM and timer untouched while reset is held with a request pending.
    assign acc_wr = rst_n && (state_q == IDLE) && cpu.wvalid_cpu;
    assign acc_rd = rst_n && (state_q == IDLE) && !cpu.wvalid_cpu && cpu.rready_cpu;
    assign accept = acc_wr || acc_rd;

    assign ram_en    = accept && ram_hit;
    assign ram_we    = (acc_wr && ram_hit) ? cpu.strb_cpu : 4'b0000;
    assign ram_addr  = cpu.addr_cpu[RamLsb-1:2];
    assign ram_wdata = cpu.data_cpu_o;

    mtimer #(
        .TIMER_PRESCALE(TIMER_PRESCALE)
    ) u_mtimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (acc_wr && tmr_hit),
        .wr_off   (cpu.addr_cpu[3:0]),
        .wr_strb  (cpu.strb_cpu),
        .wr_data  (cpu.data_cpu_o),
        .rd_off   (cpu.addr_cpu[3:0]),
        .rd_data  (tmr_rd_data),
        .timer_irq(timer_irq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    state_d = RELEASE;
            RELEASE: if (!cpu.rready_cpu && !cpu.wvalid_cpu) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_wr_d    = is_wr_q;
        from_ram_d = from_ram_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        if (accept) begin
            is_wr_d    = acc_wr;
            from_ram_d = ram_hit;
            err_d      = !(ram_hit || tmr_hit);
            rdata_d    = (acc_rd && tmr_hit) ? tmr_rd_data : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_q    <= 1'b0;
            from_ram_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            is_wr_q    <= is_wr_d;
            from_ram_q <= from_ram_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        cpu.rvalid_cpu = 1'b0;
        cpu.wready_cpu = 1'b0;
        cpu.data_cpu_i = '0;
        bus_err        = 1'b0;
        if (state_q == RESP) begin
            cpu.rvalid_cpu = !is_wr_q;
            cpu.wready_cpu = is_wr_q;
            bus_err        = err_q;
            if (!is_wr_q) begin
                cpu.data_cpu_i = from_ram_q ? ram_rdata : rdata_q;
            end
        end
    end

endmodule

// File: doc/lsu_mmio_bridge.md
Name: lsu_mmio_bridge

Overview:
Downstream neighbour of the RV32 core's load/store port. It takes the core's read and write request handshakes, decodes the byte address, and routes each access to one of two targets: the synchronous data RAM or an internal machine timer (mtime/mtimecmp). It produces the `timer_irq` input that the core's trap/CSR unit consumes. Data and strobes arrive from the core already lane-formatted; the bridge returns full 32-bit words.

Parameters:
ADDR_WIDTH_D, 10, data RAM word-address width (RAM size = 4·2^ADDR_WIDTH_D bytes)
RAM_BASE, 32'h0000_0000, byte base address of the data RAM
TIMER_BASE, 32'h0200_0000, byte base address of the timer register window (16 bytes)
TIMER_PRESCALE, 1, clock cycles per mtime increment (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rready_cpu  in  1  read request from core, held until rvalid_cpu
rvalid_cpu  out  1  one-cycle read-done pulse; data_cpu_i valid that cycle
wvalid_cpu  in  1  write request from core, held until wready_cpu
wready_cpu  out  1  one-cycle write-accepted pulse
strb_cpu  in  4  byte-lane write strobes
addr_cpu  in  32  byte address
data_cpu_o  in  32  write data, lane-aligned
data_cpu_i  out  32  read data word
ram_en  out  1  RAM access enable
ram_we  out  4  RAM byte write enables
ram_addr  out  ADDR_WIDTH_D  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid 1 cycle after ram_en
timer_irq  out  1  registered mtime >= mtimecmp
bus_err  out  1  one-cycle pulse on an unmapped access

Behaviour:
- States: IDLE, RESP, RELEASE.
- Reset values: state=IDLE; rvalid_cpu=0; wready_cpu=0; data_cpu_i=0; bus_err=0; ram_en=0; ram_we=0; mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; timer_irq=0; prescaler=0.
- IDLE:
  - If wvalid_cpu: decode, perform the write at this clock edge, go to RESP.
  - Else if rready_cpu: decode, issue the read, go to RESP.
  - If both requests are high, the write wins and the read is ignored.
- RAM address hit: `addr_cpu[31:ADDR_WIDTH_D+2] == RAM_BASE[31:ADDR_WIDTH_D+2]`.
  - In IDLE, ram_en, ram_addr and ram_we are driven combinationally: ram_addr = addr_cpu[ADDR_WIDTH_D+1:2]; ram_we = strb_cpu on a write, 0 on a read.
  - ram_wdata = data_cpu_o.
- Timer hit: addr_cpu[31:4] == TIMER_BASE[31:4]. Word offsets:
  - 0x0 mtime_lo
  - 0x4 mtime_hi
  - 0x8 mtimecmp_lo
  - 0xC mtimecmp_hi
  - Writes honour strb_cpu per byte. Reads return the value at the accept edge, registered into data_cpu_i.
- Unmapped access: write dropped, read returns 0, bus_err pulses in the RESP cycle. The handshake still completes.
- RESP (exactly 1 cycle after accept):
  - rvalid_cpu=1 for reads; data_cpu_i = ram_rdata for a RAM hit, otherwise the registered timer value or 0.
  - wready_cpu=1 for writes.
  - Next state RELEASE.
- RELEASE: remain until rready_cpu=0 and wvalid_cpu=0, then go to IDLE. No second response is ever issued for one held request.
- Latency: accept → response = 1 cycle. Minimum gap between two accepts = 3 cycles.
- mtime counting:
  - Increments by 1 when the prescaler reaches TIMER_PRESCALE-1; the prescaler then wraps to 0.
  - mtime wraps from 2^64-1 to 0.
  - A CPU write to mtime in the same cycle as an increment: the write wins for the strobed bytes; unwritten bytes take the pre-increment value.
- timer_irq is registered: it reflects mtime >= mtimecmp (unsigned 64-bit) one cycle after either register changes.
- Asynchronous reset during RESP or RELEASE: returns to IDLE with all outputs at their reset values. An in-flight RAM write already clocked remains in RAM.

Decomposition:
- Package lsu_map_pkg:
  - RAM_BASE and TIMER_BASE defaults
  - timer offsets MTIME_LO=4'h0, MTIME_HI=4'h4, MTIMECMP_LO=4'h8, MTIMECMP_HI=4'hC
  - bridge_state_t enum {IDLE, RESP, RELEASE}
- Sub-module mtimer: holds mtime, mtimecmp, prescaler and the irq compare. Ports are clk, rst_n, wr_en, wr_off, wr_strb, wr_data, rd_off, rd_data and timer_irq.
- The bridge keeps the FSM, address decode and RAM steering.

Test Plan:
1. RAM write then read:
   - Stimulus: write 0xDEADBEEF to 0x0000_0010 with strb=4'b1111, then read 0x10.
   - Response: wready_cpu pulses 1 cycle after accept and ram_addr=4; rvalid_cpu pulses 1 cycle after accept with data_cpu_i=0xDEADBEEF.
2. Byte write:
   - Stimulus: with word 0x10 = 0xDEADBEEF, write data 0x0000_5500 with strb=4'b0010, then read 0x10.
   - Response: 0xDEAD55EF.
3. Timer irq:
   - Stimulus: TIMER_PRESCALE=1, write mtimecmp_hi=0 then mtimecmp_lo=20 after reset.
   - Response: timer_irq rises the cycle after mtime reaches 20. Writing mtimecmp_hi=0xFFFF_FFFF clears timer_irq one cycle later.
4. Held request:
   - Stimulus: hold rready_cpu high for 5 cycles.
   - Response: exactly one rvalid_cpu pulse; the FSM stays in RELEASE until rready_cpu drops.
5. Unmapped access:
   - Stimulus: read 0x1000_0000.
   - Response: data_cpu_i=0 and rvalid_cpu=1 and bus_err=1 in the same cycle; RAM is untouched.
6. Reset mid-access and write priority:
   - Stimulus: assert rst_n=0 during RESP; then assert rready_cpu and wvalid_cpu together on RAM.
   - Response: all outputs return to reset values at once; only the write is performed and wready_cpu pulses.
